fp32_tap_accum: RTL
===================

// Module: fp32_tap_accum
// PURPOSE
//   Serial FP32 accumulator for one sym4 filter output: sums NTAPS tap products (h[k]*x[n-k]) per frame.
//   Sits between the tap multiplier stage and the coefficient/output store.
//   Instantiates one fp32_adder_sub_comb (op=0) and feeds the adder's registered result back as the running sum.
//   Sustains one term per clock, with back-to-back frames.
// PARAMETERS
//   NTAPS  8  terms per frame (tap count); legal range 2..256
//   CNT_W  3  term-counter width; must satisfy 2**CNT_W >= NTAPS
// PORTS
//   clk       in   1   clock; all state updates on the rising edge
//   rstn      in   1   asynchronous active-low reset
//   in_valid  in   1   in_data/in_neg valid this cycle
//   in_ready  out  1   block accepts the term this cycle (combinational)
//   in_data   in   32  FP32 tap product
//   in_neg    in   1   1: subtract term (block flips in_data[31] before the adder)
//   flush     in   1   synchronous abort of the partial frame
//   out_valid out  1   out_data holds a completed frame sum
//   out_ready in   1   downstream takes out_data this cycle
//   out_data  out  32  FP32 frame sum
//   busy      out  1   partial frame in progress (cnt != 0)
// BEHAVIOUR
//   Reset: cnt=0, fin_pend=0, out_valid=0, out_data=32'h0, busy=0; the adder's registers clear via rstn.
//     Handshakes while rstn=0 are ignored.
//   Accept: acc = in_valid && in_ready. cnt counts accepted terms (0..NTAPS-1); it wraps to 0 on the last term.
//   in_ready = !flush && ((cnt != NTAPS-1) || !out_valid || out_ready).
//     Non-last terms are never stalled.
//     The last term is accepted only if the output register is empty or drains that cycle.
//     NTAPS>=2 guarantees the register is free one cycle later.
//   Adder input mux (every cycle):
//     acc && cnt==0  : dina = term, dinb = 32'h0            (starts a new frame)
//     acc && cnt!=0  : dina = term, dinb = adder result      (running sum)
//     !acc           : dina = 32'h0, dinb = adder result     (bubble; sum held, +0 added)
//     The term is in_data with bit 31 XOR in_neg.
//   Adder valid_in = acc. The adder's valid_out is unused.
//   fin_pend <= acc && (cnt == NTAPS-1).
//   While fin_pend=1: out_data <= adder result, out_valid <= 1.
//   Latency: last term accepted in cycle t -> sum in the adder register in t+1 -> out_valid=1 in cycle t+2.
//   Output: out_valid stays high and out_data stays stable until out_ready=1; out_valid then clears next edge.
//     A capture in the same cycle as a drain reloads the register and keeps out_valid=1.
//   Frames are back-to-back: a first term accepted in cycle t+1 (cnt=0) uses dinb=0.
//     The result in flight is not disturbed; it is captured from the adder register at the end of t+1.
//   flush=1: cnt <= 0 and in_ready=0, so the concurrent term is dropped. fin_pend, out_valid and out_data are unaffected.
//   Numerics are exactly those of the adder:
//     subnormal inputs are treated as unnormalised; underflow flushes to +0; exp>=255 saturates to signed Inf;
//     the mantissa truncates (no rounding); -0 becomes +0.
//   busy = (cnt != 0).
//   Reset mid-frame discards the partial sum and any pending or held output; the first term after reset starts a new frame.
// TESTING
//   1) 8 terms of 0x3F800000 (1.0), in_valid=1 continuously, out_ready=1
//      -> out_valid pulses exactly 2 cycles after the 8th accept, out_data=0x41000000 (8.0).
//   2) 8 x 1.0 with in_neg=1 on terms 5..8 -> out_data=0x00000000.
//      Terms {2.0, -0.5, ...six 0s} -> out_data=0x3FC00000 (1.5).
//   3) 16 consecutive terms of 0x40000000 (2.0), out_ready=1 -> two outputs of 0x41800000 (16.0).
//      in_ready stays 1 throughout; outputs 8 cycles apart.
//   4) Backpressure: out_ready=0 after frame 1.
//      -> frame 2 terms 1..7 accepted, in_ready=0 at term 8, out_data held stable.
//      Raising out_ready -> term 8 accepted the same cycle, frame 2 sum appears 2 cycles later.
//   5) Bubbles: 8 x 0x3F000000 (0.5) with in_valid toggling 1,0 -> out_data=0x40800000 (4.0); out_valid 2 cycles after last accept.
//   6) 3 terms of 1.0, then flush=1 alongside a valid term, then 8 x 0.5 -> single output 0x40800000 (4.0).
//      Repeat with rstn pulsed low mid-frame: out_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/fp32_tap_accum.sv
// Serial FP32 tap accumulator: sums NTAPS tap products per frame through a
// single registered FP32 adder whose output is fed back as the running sum.
// One term per clock, back-to-back frames, one-entry output register.

// Single-precision add/sub with a registered result.
// Numerics: exp==0 operands are used as-is (no hidden bit), mantissa
// alignment and normalisation truncate, underflow flushes to +0,
// exp>=255 saturates to signed Inf, and a zero result is always +0.
module fp32_adder_sub_comb (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic        op,
    input  logic [31:0] dina,
    input  logic [31:0] dinb,
    output logic        valid_out,
    output logic [31:0] result
);
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        swap;
    logic        sl, ss;
    logic [7:0]  el, es, ediff;
    logic [23:0] ml, ms, ms_sh;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [23:0] man;
    logic [9:0]  eres;
    logic [31:0] res_d;

    // Unpack, align the smaller magnitude, add/sub, normalise, pack.
    always_comb begin
        sa    = dina[31];
        sb    = dinb[31] ^ op;
        ea    = dina[30:23];
        eb    = dinb[30:23];
        ma    = {|ea, dina[22:0]};
        mb    = {|eb, dinb[22:0]};
        swap  = {eb, mb} > {ea, ma};
        sl    = swap ? sb : sa;
        ss    = swap ? sa : sb;
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        ml    = swap ? mb : ma;
        ms    = swap ? ma : mb;
        ediff = el - es;
        ms_sh = ms >> ediff;
        if (sl == ss) sum = {1'b0, ml} + {1'b0, ms_sh};
        else          sum = {1'b0, ml} - {1'b0, ms_sh};
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (sum[i]) lz = 5'(23 - i);
        end
        if (sum[24]) begin
            man  = sum[24:1];
            eres = {2'b00, el} + 10'd1;
        end else begin
            man  = sum[23:0] << lz;
            eres = {2'b00, el} - {5'b00000, lz};
        end
        if (sum == 25'd0 || eres[9] || eres == 10'd0) res_d = 32'h0;
        else if (eres >= 10'd255)                     res_d = {sl, 8'hFF, 23'h0};
        else                                          res_d = {sl, eres[7:0], man[22:0]};
    end

    // Result and valid registers; the result updates every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result    <= 32'h0;
            valid_out <= 1'b0;
        end else begin
            result    <= res_d;
            valid_out <= valid_in;
        end
    end
endmodule

module fp32_tap_accum #(
    parameter int NTAPS = 8,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_neg,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NTAPS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fin_pend_q;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic             acc, is_last;
    logic [31:0]      term, dina, dinb, sum;
    logic             add_vld_unused;

    assign is_last   = (cnt_q == LAST);
    // The last term may only go in when the output register will be free
    // by the time its sum is ready to be captured.
    assign in_ready  = !flush && (!is_last || !out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign term      = {in_data[31] ^ in_neg, in_data[30:0]};
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (cnt_q != '0);

    // Adder operand mux: a new frame starts from +0, bubbles add +0 to hold the sum.
    always_comb begin
        dina = acc ? term : 32'h0;
        dinb = (acc && cnt_q == '0) ? 32'h0 : sum;
    end

    // Term counter: wraps on the last term, cleared by flush.
    always_comb begin
        cnt_d = cnt_q;
        if (flush)        cnt_d = '0;
        else if (acc)     cnt_d = is_last ? '0 : cnt_q + 1'b1;
    end

    fp32_adder_sub_comb u_add (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (acc),
        .op        (1'b0),
        .dina      (dina),
        .dinb      (dinb),
        .valid_out (add_vld_unused),
        .result    (sum)
    );

    // Frame control and output register; a capture wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            fin_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
        end else begin
            cnt_q      <= cnt_d;
            fin_pend_q <= acc && is_last;
            if (fin_pend_q) begin
                out_data_q  <= sum;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
